// File: rtl/mem_stage_lsu_pkg.sv
// Op codes, FSM encoding and op-decode helpers shared by the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_NONE = 2'd0,
    SIZE_B    = 2'd1,
    SIZE_H    = 2'd2,
    SIZE_W    = 2'd3
  } mem_size_e;

  // Unknown op codes decode as SIZE_NONE and therefore behave like MEM_NOP.
  function automatic mem_size_e op_size(mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return SIZE_B;
      MEM_LH, MEM_LHU, MEM_SH: return SIZE_H;
      MEM_LW, MEM_SW:          return SIZE_W;
      default:                 return SIZE_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(mem_op_e op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic op_is_store(mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic op_misaligned(mem_op_e op, logic [1:0] offset);
    case (op_size(op))
      SIZE_H:  return offset[0];
      SIZE_W:  return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for a 32-bit data bus: store byte enables and replicated write
// data, plus load lane extraction with sign/zero extension. Purely combinational.
module mem_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (op_size(op))
      SIZE_B: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_H: begin
        be    = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      SIZE_W:  be = 4'hF;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
      MEM_LBU: load_data = {24'd0, byte_lane};
      MEM_LH:  load_data = {{16{half_lane[15]}}, half_lane};
      MEM_LHU: load_data = {16'd0, half_lane};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: runs loads/stores over a req/gnt/rvalid data bus, stalls upstream
// until the access completes or times out, and passes ALU and CSR results through.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                      reg_we_i,
  input  logic [DATA_WIDTH-1:0]     reg_wdata_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [DATA_WIDTH-1:0]     mem_data_i,
  input  logic                      mem_we_i,
  input  logic [3:0]                mem_op_i,
  input  logic                      csr_we_i,
  input  logic [ADDR_WIDTH-1:0]     csr_waddr_i,
  input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
  output logic                      reg_we_o,
  output logic [DATA_WIDTH-1:0]     reg_wdata_o,
  output logic                      csr_we_o,
  output logic [ADDR_WIDTH-1:0]     csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      stall_req_o,
  output logic                      misalign_o,
  output logic                      bus_err_o,
  output logic                      dbus_req_o,
  output logic                      dbus_we_o,
  output logic [ADDR_WIDTH-1:0]     dbus_addr_o,
  output logic [3:0]                dbus_be_o,
  output logic [DATA_WIDTH-1:0]     dbus_wdata_o,
  input  logic                      dbus_gnt_i,
  input  logic                      dbus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     dbus_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e            state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  mem_op_e               op;
  logic                  is_load, is_mem, misaligned, timeout;
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata, load_data;
  logic                  stall, req, reg_we, mis, err;
  logic [DATA_WIDTH-1:0] reg_wdata;

  assign op         = mem_op_e'(mem_op_i);
  assign is_load    = op_is_load(op);
  assign is_mem     = is_load | op_is_store(op);
  assign misaligned = op_misaligned(op, mem_addr_i[1:0]);
  // cnt equals the number of cycles since the access was issued from IDLE.
  assign timeout    = (state != LSU_IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES));

  mem_lsu_align u_align (
    .op         (op),
    .offset     (mem_addr_i[1:0]),
    .store_data (mem_data_i),
    .rdata      (dbus_rdata_i),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= LSU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt == LSU_IDLE) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    req       = 1'b0;
    reg_we    = 1'b0;
    reg_wdata = reg_wdata_i;
    mis       = 1'b0;
    err       = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (!is_mem) begin
          reg_we = reg_we_i;
        end else if (misaligned) begin
          mis = 1'b1;
        end else begin
          req       = 1'b1;
          stall     = 1'b1;
          state_nxt = dbus_gnt_i ? LSU_WAIT : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (timeout) begin
          err       = 1'b1;
          state_nxt = LSU_IDLE;
        end else begin
          req   = 1'b1;
          stall = 1'b1;
          if (dbus_gnt_i) state_nxt = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (timeout) begin
          err       = 1'b1;
          state_nxt = LSU_IDLE;
        end else if (dbus_rvalid_i) begin
          reg_we    = reg_we_i;
          reg_wdata = is_load ? load_data : reg_wdata_i;
          state_nxt = LSU_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

  // Everything is forced quiet while reset is held, including the pass-through paths.
  assign stall_req_o  = ~rst_i & stall;
  assign dbus_req_o   = ~rst_i & req;
  assign misalign_o   = ~rst_i & mis;
  assign bus_err_o    = ~rst_i & err;
  assign reg_we_o     = ~rst_i & reg_we;
  assign reg_wdata_o  = rst_i ? '0 : reg_wdata;
  assign reg_waddr_o  = rst_i ? '0 : reg_waddr_i;
  assign csr_we_o     = ~rst_i & csr_we_i;
  assign csr_waddr_o  = rst_i ? '0 : csr_waddr_i;
  assign csr_wdata_o  = rst_i ? '0 : csr_wdata_i;
  assign dbus_we_o    = dbus_req_o & mem_we_i;
  assign dbus_addr_o  = dbus_req_o ? {mem_addr_i[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dbus_be_o    = dbus_req_o ? lane_be : 4'b0000;
  assign dbus_wdata_o = dbus_req_o ? lane_wdata : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized bench for mem_stage_lsu, checked every cycle against a
// transaction-level model of an in-flight access.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int T = 8;

  logic        clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;
  logic [4:0]  reg_waddr_i, reg_waddr_o;
  logic        reg_we_i, reg_we_o;
  logic [31:0] reg_wdata_i, reg_wdata_o;
  logic [31:0] mem_addr_i, mem_data_i;
  logic        mem_we_i;
  logic [3:0]  mem_op_i;
  logic        csr_we_i, csr_we_o;
  logic [31:0] csr_waddr_i, csr_wdata_i, csr_waddr_o, csr_wdata_o;
  logic        stall_req_o, misalign_o, bus_err_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;

  mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_we_i(mem_we_i), .mem_op_i(mem_op_i),
    .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_req_o(stall_req_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model of the access in flight: issued, whether granted, cycles since issue.
  bit busy = 0;
  bit granted = 0;
  int elapsed = 0;
  bit e_stall = 0;

  logic        s_stall, s_req, s_mis, s_err, s_reg_we;
  logic [31:0] s_addr, s_wdata, s_reg_wdata;
  logic [3:0]  s_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_bytes(input logic [3:0] op);
    case (mem_op_e'(op))
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit ld_op(input logic [3:0] op);
    return op_bytes(op) != 0 && !(op == MEM_SB || op == MEM_SH || op == MEM_SW);
  endfunction

  function automatic logic [31:0] load_value(input logic [3:0] op, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * off)) & 32'hFF;
    h = (rdata >> (16 * off[1])) & 32'hFFFF;
    case (mem_op_e'(op))
      MEM_LB:  return (b ^ 32'h80) - 32'h80;
      MEM_LBU: return b;
      MEM_LH:  return (h ^ 32'h8000) - 32'h8000;
      MEM_LHU: return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input int n, input logic [31:0] d);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  task automatic check_cycle();
    bit e_req, e_reg_we, e_mis, e_err;
    logic [31:0] e_reg_wdata;
    int n;
    int off;
    s_stall = stall_req_o; s_req = dbus_req_o; s_mis = misalign_o; s_err = bus_err_o;
    s_reg_we = reg_we_o; s_addr = dbus_addr_o; s_wdata = dbus_wdata_o; s_be = dbus_be_o;
    s_reg_wdata = reg_wdata_o;
    if (rst_i) begin
      chk("reset_ctrl", {25'd0, stall_req_o, dbus_req_o, misalign_o, bus_err_o, reg_we_o,
                         csr_we_o, dbus_we_o}, 32'd0);
      chk("reset_data", reg_wdata_o | dbus_addr_o | dbus_wdata_o | csr_wdata_o | csr_waddr_o, 32'd0);
      chk("reset_misc", {23'd0, reg_waddr_o, dbus_be_o}, 32'd0);
      busy = 0;
      e_stall = 0;
      return;
    end
    n = op_bytes(mem_op_i);
    off = int'(mem_addr_i[1:0]);
    e_stall = 0; e_req = 0; e_reg_we = 0; e_mis = 0; e_err = 0;
    e_reg_wdata = reg_wdata_i;
    if (!busy) begin
      if (n == 0) e_reg_we = reg_we_i;
      else if (off % n != 0) e_mis = 1;
      else begin
        e_req = 1; e_stall = 1;
        busy = 1; granted = dbus_gnt_i; elapsed = 1;
      end
    end else if (elapsed == T) begin
      e_err = 1; busy = 0;
    end else if (!granted) begin
      e_req = 1; e_stall = 1;
      granted = dbus_gnt_i; elapsed++;
    end else if (dbus_rvalid_i) begin
      e_reg_we = reg_we_i;
      if (ld_op(mem_op_i)) e_reg_wdata = load_value(mem_op_i, mem_addr_i[1:0], dbus_rdata_i);
      busy = 0;
    end else begin
      e_stall = 1; elapsed++;
    end
    chk("stall", stall_req_o, e_stall);
    chk("dbus_req", dbus_req_o, e_req);
    chk("misalign", misalign_o, e_mis);
    chk("bus_err", bus_err_o, e_err);
    chk("reg_we", reg_we_o, e_reg_we);
    if (e_req) begin
      chk("dbus_addr", dbus_addr_o, mem_addr_i & ~32'h3);
      chk("dbus_be", dbus_be_o, 32'(((1 << n) - 1) << off));
      chk("dbus_wdata", dbus_wdata_o, lane_data(n, mem_data_i));
      chk("dbus_we", dbus_we_o, mem_we_i);
    end
    if (!e_stall) begin
      chk("reg_waddr", reg_waddr_o, reg_waddr_i);
      chk("csr", {31'd0, csr_we_o} ^ csr_waddr_o ^ {csr_wdata_o[15:0], csr_wdata_o[31:16]},
          {31'd0, csr_we_i} ^ csr_waddr_i ^ {csr_wdata_i[15:0], csr_wdata_i[31:16]});
      chk("csr_wdata", csr_wdata_o, csr_wdata_i);
      if (!e_mis && !e_err) chk("reg_wdata", reg_wdata_o, e_reg_wdata);
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are checked on the falling edge.
  task automatic tick();
    #4;
    check_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    mem_op_i = op; mem_addr_i = addr; mem_data_i = data;
    mem_we_i = (op == MEM_SB || op == MEM_SH || op == MEM_SW);
    reg_we_i = 1'($urandom_range(0, 1)); reg_waddr_i = 5'($urandom); reg_wdata_i = $urandom;
    csr_we_i = 1'($urandom_range(0, 1)); csr_waddr_i = $urandom; csr_wdata_i = $urandom;
  endtask

  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input int gnt_delay, input bit stray,
                        output logic [3:0] be0, output logic [31:0] wdata0, output logic [31:0] addr0,
                        output logic stall0, output logic stall_last, output logic [31:0] result,
                        output int req_cycles, output int accepted);
    set_instr(op, addr, data);
    req_cycles = 0; accepted = 0;
    be0 = '0; wdata0 = '0; addr0 = '0; stall0 = 0;
    for (int i = 0; i <= gnt_delay; i++) begin
      dbus_gnt_i = (i == gnt_delay);
      dbus_rvalid_i = stray;
      dbus_rdata_i = ~rdata;
      tick();
      if (i == 0) begin be0 = s_be; wdata0 = s_wdata; addr0 = s_addr; stall0 = s_stall; end
      if (s_req) req_cycles++;
      if (s_req && dbus_gnt_i) accepted++;
    end
    dbus_gnt_i = 0; dbus_rvalid_i = 1; dbus_rdata_i = rdata;
    tick();
    result = s_reg_wdata; stall_last = s_stall;
    dbus_rvalid_i = 0;
    set_instr(MEM_NOP, 32'd0, 32'd0);
  endtask

  initial begin
    logic [3:0]  be0;
    logic [31:0] wdata0, addr0, result;
    logic        stall0, stall_last;
    int          req_cycles, accepted, err_at;
    bit          adv;

    rst_i = 1; dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0;
    set_instr(MEM_NOP, 32'd0, 32'd0);
    @(posedge clk_i); #1;
    tick();
    tick();
    rst_i = 0;
    tick();

    access(MEM_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, be0, wdata0, addr0, stall0, stall_last,
           result, req_cycles, accepted);
    chk("lw_addr", addr0, 32'h100);
    chk("lw_be", {28'd0, be0}, 32'hF);
    chk("lw_stall_seq", {30'd0, stall0, stall_last}, 32'b10);
    chk("lw_data", result, 32'hDEADBEEF);

    access(MEM_LB, 32'h103, 32'h0, 32'h80123456, 0, 0, be0, wdata0, addr0, stall0, stall_last,
           result, req_cycles, accepted);
    chk("lb_sext", result, 32'hFFFFFF80);
    access(MEM_LBU, 32'h103, 32'h0, 32'h80123456, 0, 0, be0, wdata0, addr0, stall0, stall_last,
           result, req_cycles, accepted);
    chk("lbu_zext", result, 32'h00000080);
    access(MEM_LH, 32'h102, 32'h0, 32'h80011234, 0, 0, be0, wdata0, addr0, stall0, stall_last,
           result, req_cycles, accepted);
    chk("lh_sext", result, 32'hFFFF8001);

    access(MEM_SB, 32'h201, 32'h000000AB, 32'h0, 0, 0, be0, wdata0, addr0, stall0, stall_last,
           result, req_cycles, accepted);
    chk("sb_be", {28'd0, be0}, 32'h2);
    chk("sb_wdata", wdata0, 32'hABABABAB);
    access(MEM_SH, 32'h202, 32'h00001234, 32'h0, 0, 0, be0, wdata0, addr0, stall0, stall_last,
           result, req_cycles, accepted);
    chk("sh_be", {28'd0, be0}, 32'hC);
    chk("sh_wdata", wdata0, 32'h12341234);

    access(MEM_LW, 32'h300, 32'h0, 32'h0BADF00D, 3, 0, be0, wdata0, addr0, stall0, stall_last,
           result, req_cycles, accepted);
    chk("gnt_wait_req_cycles", req_cycles, 32'd4);
    chk("gnt_wait_accepted", accepted, 32'd1);
    chk("gnt_wait_data", result, 32'h0BADF00D);

    access(MEM_LW, 32'h600, 32'h0, 32'h12345678, 2, 1, be0, wdata0, addr0, stall0, stall_last,
           result, req_cycles, accepted);
    chk("stray_rvalid_data", result, 32'h12345678);

    set_instr(MEM_LW, 32'h101, 32'h0);
    reg_we_i = 1;
    tick();
    chk("misalign_flags", {28'd0, s_mis, s_req, s_reg_we, s_stall}, 32'b1000);
    set_instr(MEM_NOP, 32'd0, 32'd0);
    tick();

    set_instr(MEM_LW, 32'h400, 32'h0);
    dbus_gnt_i = 1;
    err_at = -1;
    for (int i = 0; i < 20 && err_at < 0; i++) begin
      tick();
      dbus_gnt_i = 0;
      if (s_err) err_at = i;
    end
    chk("timeout_cycle", err_at, 32'd8);
    set_instr(MEM_NOP, 32'd0, 32'd0);
    tick();

    set_instr(MEM_LW, 32'h500, 32'h0);
    dbus_gnt_i = 1;
    tick();
    dbus_gnt_i = 0;
    tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    set_instr(MEM_NOP, 32'd0, 32'd0);
    reg_wdata_i = 32'h11111111;
    dbus_rvalid_i = 1; dbus_rdata_i = 32'hFFFFFFFF;
    tick();
    chk("late_rvalid_ignored", s_reg_wdata, 32'h11111111);
    chk("late_rvalid_quiet", {30'd0, s_stall, s_req}, 32'd0);
    dbus_rvalid_i = 0;

    adv = 1;
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      if (adv) begin
        logic [3:0] rop;
        logic [31:0] ra;
        int n;
        rop = 4'($urandom_range(0, 11));
        ra = $urandom;
        n = op_bytes(rop);
        if (n > 1 && $urandom_range(0, 3) != 0) ra = ra & ~32'(n - 1);
        set_instr(rop, ra, $urandom);
      end
      dbus_gnt_i = 1'($urandom_range(0, 1));
      dbus_rvalid_i = ($urandom_range(0, 3) == 0);
      dbus_rdata_i = $urandom;
      tick();
      adv = !e_stall;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
